// File: rtl/dct_blk_buf.sv
// Ping-pong 8-line buffer that reorders raster beats into 8x8 block rows; DCT_BLK_LEVEL_SHIFT_EN stores pixel-128.
// First row 2 cycles after stripe handover, then one row/cycle; outputs hold while stalled, stripe dropped if both banks full.
module dct_blk_buf #(
    parameter int H_ACTIVE = 240,
    parameter int BIDX_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [63:0]       pix_in,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [63:0]       blk_data,
    output logic [2:0]        blk_row,
    output logic [BIDX_W-1:0] blk_idx,
    output logic              blk_sof,
    output logic              ovf,
    output logic              len_err
);
    localparam int DEPTH = 8 * H_ACTIVE;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(H_ACTIVE + 1);

`ifdef DCT_BLK_LEVEL_SHIFT_EN
    localparam logic [63:0] SHIFT_MASK = {8{8'h80}};
`else
    localparam logic [63:0] SHIFT_MASK = '0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_state_t;

    logic [63:0] mem [2][DEPTH];

    logic          armed, frame_first, de_d, dropping, wr_bank, beat_extra;
    logic [BW-1:0] beat;
    logic [2:0]    wr_line;
    logic [1:0]    bank_full, bank_sof;
    logic          stripe_start, drop_now, wr_en, line_end, handover;
    logic [AW-1:0] wr_addr;

    rd_state_t         state, state_nxt;
    logic              rd_bank;
    logic [2:0]        rd_row;
    logic [BIDX_W-1:0] rd_idx;
    logic              issue, last_issue, release_bank, other_full;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        stripe_start = armed && vs_in && de_in && (wr_line == 3'd0) && (beat == '0);
        drop_now     = stripe_start ? bank_full[wr_bank] : dropping;
        wr_en        = armed && vs_in && de_in && (beat < BW'(H_ACTIVE)) && !drop_now;
        line_end     = armed && vs_in && de_d && !de_in;
        handover     = line_end && (wr_line == 3'd7) && !dropping;
        wr_addr      = AW'(wr_line) * AW'(H_ACTIVE) + AW'(beat);
    end

    // Level shift is applied on the way in so the read path stays a plain registered RAM read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= pix_in ^ SHIFT_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            frame_first <= 1'b0;
            de_d        <= 1'b0;
            dropping    <= 1'b0;
            wr_bank     <= 1'b0;
            beat_extra  <= 1'b0;
            beat        <= '0;
            wr_line     <= '0;
            bank_sof    <= '0;
            ovf         <= 1'b0;
            len_err     <= 1'b0;
        end else if (!vs_in) begin
            armed       <= 1'b1;
            frame_first <= 1'b1;
            de_d        <= 1'b0;
            dropping    <= 1'b0;
            beat_extra  <= 1'b0;
            beat        <= '0;
            wr_line     <= '0;
        end else if (armed) begin
            de_d <= de_in;
            if (stripe_start) begin
                frame_first <= 1'b0;
                dropping    <= bank_full[wr_bank];
                if (bank_full[wr_bank]) ovf <= 1'b1;
                else                    bank_sof[wr_bank] <= frame_first;
            end
            if (de_in) begin
                if (beat == BW'(H_ACTIVE)) beat_extra <= 1'b1;
                else                       beat <= beat + BW'(1);
            end else if (line_end) begin
                if ((beat != BW'(H_ACTIVE)) || beat_extra) len_err <= 1'b1;
                beat       <= '0;
                beat_extra <= 1'b0;
                wr_line    <= wr_line + 3'd1;
                if (handover) wr_bank <= ~wr_bank;
                if (wr_line == 3'd7) dropping <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        issue        = (state == R_RUN) && (!blk_valid || blk_ready);
        last_issue   = issue && (rd_row == 3'd7) && (rd_idx == BIDX_W'(H_ACTIVE - 1));
        release_bank = (state == R_DRAIN) && blk_valid && blk_ready;
        // A handover landing on the release cycle lets the next stripe start without an idle cycle.
        other_full   = bank_full[~rd_bank] || (handover && (wr_bank != rd_bank));
        rd_addr      = AW'(rd_row) * AW'(H_ACTIVE) + AW'(rd_idx);
        case (state)
            R_IDLE:  if (bank_full[rd_bank]) state_nxt = R_RUN;
            R_RUN:   if (last_issue) state_nxt = R_DRAIN;
            R_DRAIN: if (release_bank) state_nxt = other_full ? R_RUN : R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            bank_full <= '0;
            rd_bank   <= 1'b0;
            rd_row    <= '0;
            rd_idx    <= '0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_row   <= '0;
            blk_idx   <= '0;
            blk_sof   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (release_bank) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
            if (handover) bank_full[wr_bank] <= 1'b1;
            if (issue) begin
                blk_valid <= 1'b1;
                blk_data  <= mem[rd_bank][rd_addr];
                blk_row   <= rd_row;
                blk_idx   <= rd_idx;
                blk_sof   <= bank_sof[rd_bank] && (rd_row == 3'd0) && (rd_idx == '0);
                if (rd_row == 3'd7) begin
                    rd_row <= 3'd0;
                    rd_idx <= last_issue ? '0 : rd_idx + BIDX_W'(1);
                end else begin
                    rd_row <= rd_row + 3'd1;
                end
            end else if (blk_ready) begin
                blk_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dct_blk_buf.sv
// Randomised bench for dct_blk_buf: stripe-level model of the two banks and the expected block-row stream.
module tb_dct_blk_buf;
    localparam int H   = 240;
    localparam int BW  = 8;
    localparam int GAP = 8;
`ifdef DCT_BLK_LEVEL_SHIFT_EN
    localparam logic [63:0] LS_MASK = {8{8'h80}};
`else
    localparam logic [63:0] LS_MASK = '0;
`endif

    logic          clk = 1'b0;
    logic          rst, vs_in, de_in;
    logic [63:0]   pix_in;
    logic          blk_valid, blk_sof, ovf, len_err;
    logic          blk_ready = 1'b0;
    logic [63:0]   blk_data;
    logic [2:0]    blk_row;
    logic [BW-1:0] blk_idx;

    dct_blk_buf #(.H_ACTIVE(H), .BIDX_W(BW)) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_row(blk_row), .blk_idx(blk_idx), .blk_sof(blk_sof),
        .ovf(ovf), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]   dat;
        logic [2:0]    row;
        logic [BW-1:0] idx;
        logic          sof;
        logic          last;
    } exp_t;

    logic [63:0] mdl_mem [2][8][H];
    exp_t        exp_q[$];
    int          mdl_wb, pending, rdy_mode;
    bit          mdl_armed, frame_first, drop, cur_sof, mdl_ovf, mdl_len, bubble_chk;
    int          n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] gen_pix(input int mode, input int ln);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            case (mode)
                0: v[8*k +: 8] = 8'(ln * 8 + k);
                1: v[8*k +: 8] = 8'($urandom_range(0, 255));
                default: case ($urandom_range(0, 2))
                    0:       v[8*k +: 8] = 8'h00;
                    1:       v[8*k +: 8] = 8'h80;
                    default: v[8*k +: 8] = 8'hFF;
                endcase
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       blk_ready = 1'b1;
            1:       blk_ready = 1'($urandom_range(0, 1));
            default: blk_ready = 1'b0;
        endcase
    end

    // Monitor: pops the expected stream on every acceptance and checks holding while stalled.
    exp_t          e;
    logic [63:0]   p_dat;
    logic [2:0]    p_row;
    logic [BW-1:0] p_idx;
    logic          p_sof;
    bit            p_stall, p_acc_mid;
    always @(negedge clk) begin
        if (rst) begin
            p_stall   = 1'b0;
            p_acc_mid = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_vld", blk_valid, 1'b1);
                chk("hold_dat", blk_data, p_dat);
                chk("hold_row", blk_row, p_row);
                chk("hold_idx", blk_idx, p_idx);
                chk("hold_sof", blk_sof, p_sof);
            end
            if (bubble_chk && p_acc_mid) chk("no_bubble", blk_valid, 1'b1);
            p_acc_mid = 1'b0;
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", blk_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_dat", blk_data, e.dat);
                    chk("row_row", blk_row, e.row);
                    chk("row_idx", blk_idx, e.idx);
                    chk("row_sof", blk_sof, e.sof);
                    if (e.last) pending--;
                    else        p_acc_mid = 1'b1;
                end
            end
            p_stall = blk_valid && !blk_ready;
            p_dat   = blk_data;
            p_row   = blk_row;
            p_idx   = blk_idx;
            p_sof   = blk_sof;
        end
    end

    task automatic send_line(input int ln, input int nb, input int mode);
        logic [63:0] p;
        exp_t        x;
        if (mdl_armed && ln == 0) begin
            drop        = (pending == 2);
            cur_sof     = frame_first;
            frame_first = 1'b0;
            if (drop) mdl_ovf = 1'b1;
        end
        if (mdl_armed && nb != H) mdl_len = 1'b1;
        for (int b = 0; b < nb; b++) begin
            p = gen_pix(mode, ln);
            @(posedge clk); #1;
            de_in  = 1'b1;
            pix_in = p;
            if (mdl_armed && !drop && b < H) mdl_mem[mdl_wb][ln][b] = p;
        end
        @(posedge clk); #1;
        de_in = 1'b0;
        if (mdl_armed && ln == 7 && !drop) begin
            for (int bi = 0; bi < H; bi++) begin
                for (int r = 0; r < 8; r++) begin
                    x.dat  = mdl_mem[mdl_wb][r][bi] ^ LS_MASK;
                    x.row  = 3'(r);
                    x.idx  = BW'(bi);
                    x.sof  = cur_sof && bi == 0 && r == 0;
                    x.last = (bi == H - 1) && (r == 7);
                    exp_q.push_back(x);
                end
            end
            mdl_wb ^= 1;
            pending++;
        end
    endtask

    task automatic send_stripe(input int mode, input int sl, input int snb, input bit lat_chk);
        for (int ln = 0; ln < 8; ln++) begin
            send_line(ln, (ln == sl) ? snb : H, mode);
            if (ln == 7 && lat_chk) begin
                @(posedge clk);
                @(posedge clk); @(negedge clk);
                chk("lat_vld_c1", blk_valid, 1'b0);
                @(posedge clk); @(negedge clk);
                chk("lat_vld_c2", blk_valid, 1'b1);
            end
            repeat (GAP) @(posedge clk);
        end
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1;
        vs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vs_in       = 1'b1;
        mdl_armed   = 1'b1;
        frame_first = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_flags(input string tag);
        @(negedge clk);
        chk({tag, "_ovf"}, ovf, mdl_ovf);
        chk({tag, "_len_err"}, len_err, mdl_len);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; pending = 0; mdl_wb = 0; rdy_mode = 0;
        mdl_armed = 0; frame_first = 0; drop = 0; cur_sof = 0;
        mdl_ovf = 0; mdl_len = 0; bubble_chk = 0;
        rst = 1'b1; vs_in = 1'b1; de_in = 1'b0; pix_in = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", blk_valid, 1'b0);
        chk("rst_sof", blk_sof, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_dat", blk_data, 64'h0);
        chk("rst_row", blk_row, 3'd0);
        chk("rst_idx", blk_idx, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp frame, consumer always ready: latency and no-bubble checks.
        vs_pulse();
        bubble_chk = 1'b1;
        send_stripe(0, -1, H, 1'b1);
        send_stripe(1, -1, H, 1'b0);
        wait_drain("drain_ramp");
        bubble_chk = 1'b0;
        check_flags("ramp");

        // Random backpressure across two stripes.
        rdy_mode = 1;
        vs_pulse();
        send_stripe(1, -1, H, 1'b0);
        send_stripe(2, -1, H, 1'b0);
        wait_drain("drain_random");
        check_flags("random");

        // Consumer stalled for three stripes: third one dropped.
        rdy_mode = 2;
        vs_pulse();
        send_stripe(1, -1, H, 1'b0);
        send_stripe(1, -1, H, 1'b0);
        send_stripe(1, -1, H, 1'b0);
        check_flags("stall");
        rdy_mode = 0;
        wait_drain("drain_stall");

        // Short line: stale word delivered, len_err raised.
        send_stripe(2, 3, H - 1, 1'b0);
        wait_drain("drain_short");
        check_flags("short");

        // Sync in the middle of a stripe abandons it; new frame starts with sof.
        for (int ln = 0; ln < 4; ln++) begin
            send_line(ln, H, 1);
            repeat (GAP) @(posedge clk);
        end
        send_line(4, 100, 1);
        vs_pulse();
        send_stripe(1, -1, H, 1'b0);
        wait_drain("drain_vs_abort");

        // Reset during a stalled readout, input ignored until the next sync.
        rdy_mode = 2;
        vs_pulse();
        send_stripe(1, -1, H, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        pending = 0; mdl_wb = 0; mdl_armed = 0; frame_first = 0;
        mdl_ovf = 0; mdl_len = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_vld", blk_valid, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_len_err", len_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 0;
        send_stripe(1, -1, H, 1'b0);
        repeat (20) @(posedge clk);
        vs_pulse();
        send_stripe(0, -1, H, 1'b0);
        wait_drain("drain_after_rst");
        check_flags("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
